// File: rtl/kbd_pkg.sv
// Shared definitions for the keypad event capture block: FSM state type,
// scanner column bit positions and the default key code width.
package kbd_pkg;

  localparam int CODE_W = 4;

  // Bit positions of the scanner columns inside SCAN_COL.
  // A frame is B, G, F, D in that order.
  localparam int COL_B = 3;
  localparam int COL_G = 2;
  localparam int COL_F = 1;
  localparam int COL_D = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } kbd_state_t;

  // True when exactly one column bit is driven.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/scan_frame_acc.sv
// Per-frame accumulator: folds the four column cycles of one scan frame into
// a single summary (any press, more than one press, first pressed code).
// The summary outputs include the inputs of the current cycle, so on the D
// cycle they describe the complete frame while frame_done is high.
module scan_frame_acc
  import kbd_pkg::*;
#(
  parameter int CODE_W = kbd_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        scan_col,
  input  logic [CODE_W-1:0] scan_data,
  input  logic              scan_press,
  output logic              frame_done,
  output logic              f_press,
  output logic              f_multi,
  output logic [CODE_W-1:0] f_code
);

  logic              acc_press;
  logic              acc_multi;
  logic [CODE_W-1:0] acc_code;
  logic              seen_b;
  logic              col_ok;

  logic              nxt_press;
  logic              nxt_multi;
  logic [CODE_W-1:0] nxt_code;

  // Malformed column drives are ignored entirely.
  assign col_ok = is_onehot4(scan_col);

  // Fold the current column into the running frame summary.
  always_comb begin
    nxt_press = acc_press;
    nxt_multi = acc_multi;
    nxt_code  = acc_code;
    if (col_ok) begin
      if (scan_col[COL_B]) begin
        // B opens a new frame, so earlier columns are forgotten.
        nxt_press = scan_press;
        nxt_code  = scan_press ? scan_data : '0;
        nxt_multi = 1'b0;
      end else if (scan_press) begin
        if (acc_press) begin
          nxt_multi = 1'b1;
        end else begin
          nxt_press = 1'b1;
          nxt_code  = scan_data;
        end
      end
    end
  end

  // A D cycle only closes a frame once some B cycle has been observed.
  assign frame_done = col_ok && scan_col[COL_D] && seen_b;
  assign f_press    = nxt_press;
  assign f_multi    = nxt_multi;
  assign f_code     = nxt_code;

  // Hold the running summary and remember whether any frame has started.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_press <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= '0;
      seen_b    <= 1'b0;
    end else if (col_ok) begin
      acc_press <= nxt_press;
      acc_multi <= nxt_multi;
      acc_code  <= nxt_code;
      if (scan_col[COL_B]) begin
        seen_b <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_capture.sv
// Keypad event capture: debounces scanned frames, latches one key code per
// physical press and hands it to the MCU through a valid/interrupt/ack
// handshake with a sticky overrun flag. No auto-repeat.
module key_event_capture
  import kbd_pkg::*;
#(
  parameter int DEB_FRAMES = 4,
  parameter int CODE_W     = kbd_pkg::CODE_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [3:0]        SCAN_COL,
  input  logic [CODE_W-1:0] SCAN_DATA,
  input  logic              SCAN_PRESS,
  input  logic              KEY_ACK,
  output logic [CODE_W-1:0] KEY_CODE,
  output logic              KEY_VALID,
  output logic              KEY_INT,
  output logic              OVERRUN
);

  localparam int              CNT_W   = $clog2(DEB_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Frame counter increment that sticks at the debounce target.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic              frame_done;
  logic              f_press;
  logic              f_multi;
  logic [CODE_W-1:0] f_code;

  kbd_state_t        state;
  kbd_state_t        state_nxt;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;
  logic              fr_none;
  logic              fr_key;

  scan_frame_acc #(
    .CODE_W (CODE_W)
  ) u_acc (
    .clk        (CLK),
    .rst_n      (RST_N),
    .scan_col   (SCAN_COL),
    .scan_data  (SCAN_DATA),
    .scan_press (SCAN_PRESS),
    .frame_done (frame_done),
    .f_press    (f_press),
    .f_multi    (f_multi),
    .f_code     (f_code)
  );

  assign fr_none = !f_press;
  assign fr_key  = f_press && !f_multi;
  assign cnt_inc = sat_inc(cnt);

  // Debounce decisions, taken only when a frame completes.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (fr_key) begin
            cand_nxt = f_code;
            cnt_nxt  = CNT_ONE;
            if (DEB_FRAMES == 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = PRESS_DEB;
            end
          end
        end
        PRESS_DEB: begin
          if (fr_key) begin
            if (f_code == cand) begin
              cnt_nxt = cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                accept    = 1'b1;
                state_nxt = HELD;
              end
            end else begin
              // A different key restarts the count for the new candidate.
              cand_nxt = f_code;
              cnt_nxt  = CNT_ONE;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        HELD: begin
          // Only an empty frame starts release; code changes are ignored.
          if (fr_none) begin
            if (DEB_FRAMES == 1) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = REL_DEB;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        REL_DEB: begin
          if (fr_none) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            state_nxt = HELD;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // FSM state plus registered handshake outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      KEY_CODE  <= '0;
      KEY_VALID <= 1'b0;
      KEY_INT   <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cand    <= cand_nxt;
      cnt     <= cnt_nxt;
      KEY_INT <= accept;
      if (accept) begin
        KEY_VALID <= 1'b1;
        if (KEY_VALID && !KEY_ACK) begin
          // Unread key still pending: keep it and flag the loss.
          OVERRUN <= 1'b1;
        end else begin
          // Acceptance wins over a simultaneous acknowledge.
          KEY_CODE <= f_code;
          OVERRUN  <= 1'b0;
        end
      end else if (KEY_ACK && KEY_VALID) begin
        KEY_VALID <= 1'b0;
        OVERRUN   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_event_capture.sv
// Directed bench for key_event_capture (DEB_FRAMES=4): a frame-level vector
// table plus hand-written reset and orphan-D sequences.
module tb_key_event_capture;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [3:0]    SCAN_COL;
  logic [CW-1:0] SCAN_DATA;
  logic          SCAN_PRESS;
  logic          KEY_ACK;
  logic [CW-1:0] KEY_CODE;
  logic          KEY_VALID;
  logic          KEY_INT;
  logic          OVERRUN;

  always #5 CLK = ~CLK;

  key_event_capture #(
    .DEB_FRAMES (4),
    .CODE_W     (CW)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SCAN_COL   (SCAN_COL),
    .SCAN_DATA  (SCAN_DATA),
    .SCAN_PRESS (SCAN_PRESS),
    .KEY_ACK    (KEY_ACK),
    .KEY_CODE   (KEY_CODE),
    .KEY_VALID  (KEY_VALID),
    .KEY_INT    (KEY_INT),
    .OVERRUN    (OVERRUN)
  );

  int n_chk = 0;
  int n_fail = 0;
  int int_pulses = 0;

  // Count cycles with KEY_INT high; each acceptance must contribute one.
  always @(negedge CLK) begin
    if (KEY_INT === 1'b1) int_pulses++;
  end

  // One scan frame and the outputs expected after its D edge.
  // ack: 0 none, 1 KEY_ACK during the D cycle, 2 one extra ack-only cycle.
  typedef struct {
    logic [3:0]  pm;
    logic [15:0] codes;
    int          ack;
    bit          junk;
    logic        mid;
    logic        v;
    logic [3:0]  c;
    logic        i;
    logic        o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] pm, input logic [15:0] codes, input int ack,
                     input bit junk, input logic mid, input logic v, input logic [3:0] c,
                     input logic i, input logic o, input int rep);
    vec_t e;
    e.pm = pm; e.codes = codes; e.ack = ack; e.junk = junk;
    e.mid = mid; e.v = v; e.c = c; e.i = i; e.o = o;
    for (int k = 0; k < rep; k++) tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_frame(input vec_t e, input int idx);
    for (int i = 3; i >= 0; i--) begin
      SCAN_COL   = 4'b0001 << i;
      SCAN_PRESS = e.pm[i];
      SCAN_DATA  = e.pm[i] ? e.codes[i*4 +: 4] : 4'hF;
      KEY_ACK    = (e.ack == 1 && i == 0);
      tick;
      if (i != 0) chk($sformatf("f%0d_valid_col%0d", idx, i), KEY_VALID, e.mid);
      if (e.junk && i == 2) begin
        SCAN_COL   = 4'b1100;
        SCAN_PRESS = 1'b1;
        SCAN_DATA  = 4'hF;
        KEY_ACK    = 1'b0;
        tick;
        chk($sformatf("f%0d_valid_junk", idx), KEY_VALID, e.mid);
      end
    end
    SCAN_COL   = 4'b0000;
    SCAN_PRESS = 1'b0;
    KEY_ACK    = 1'b0;
    if (e.ack == 2) begin
      KEY_ACK = 1'b1;
      tick;
      KEY_ACK = 1'b0;
    end
    chk($sformatf("f%0d_valid", idx), KEY_VALID, e.v);
    chk($sformatf("f%0d_code", idx), KEY_CODE, e.c);
    chk($sformatf("f%0d_int", idx), KEY_INT, e.i);
    chk($sformatf("f%0d_overrun", idx), OVERRUN, e.o);
  endtask

  initial begin
    vec_t h;
    RST_N = 1'b0; SCAN_COL = '0; SCAN_DATA = '0; SCAN_PRESS = 1'b0; KEY_ACK = 1'b0;

    // Press of 5 in G; latency checked on every column; code change while held.
    add(4'b0100, 16'h0500, 0, 0, 0, 0, 4'h0, 0, 0, 3);
    add(4'b0100, 16'h0500, 0, 0, 0, 1, 4'h5, 1, 0, 1);
    add(4'b0100, 16'h0500, 0, 0, 1, 1, 4'h5, 0, 0, 1);
    add(4'b0100, 16'h0300, 0, 0, 1, 1, 4'h5, 0, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h5, 0, 0, 4);
    add(4'b0000, 16'h0000, 2, 0, 1, 0, 4'h5, 0, 0, 1);
    // Bounce: KEY(7), NONE, KEY(7)x4.
    add(4'b1000, 16'h7000, 0, 0, 0, 0, 4'h5, 0, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 0, 0, 4'h5, 0, 0, 1);
    add(4'b1000, 16'h7000, 0, 0, 0, 0, 4'h5, 0, 0, 3);
    add(4'b1000, 16'h7000, 0, 0, 0, 1, 4'h7, 1, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h7, 0, 0, 4);
    add(4'b0000, 16'h0000, 2, 0, 1, 0, 4'h7, 0, 0, 1);
    // KEY(4), MULTI(1,4) resets the debounce, then KEY(4)x4 with junk columns.
    add(4'b0001, 16'h0004, 0, 0, 0, 0, 4'h7, 0, 0, 1);
    add(4'b0101, 16'h0104, 0, 0, 0, 0, 4'h7, 0, 0, 1);
    add(4'b0001, 16'h0004, 0, 1, 0, 0, 4'h7, 0, 0, 3);
    add(4'b0001, 16'h0004, 0, 1, 0, 1, 4'h4, 1, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h4, 0, 0, 4);
    add(4'b0000, 16'h0000, 2, 0, 1, 0, 4'h4, 0, 0, 1);
    // Overrun: 3 then 9 without ack, then ack clears.
    add(4'b0010, 16'h0030, 0, 0, 0, 0, 4'h4, 0, 0, 3);
    add(4'b0010, 16'h0030, 0, 0, 0, 1, 4'h3, 1, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h3, 0, 0, 4);
    add(4'b0100, 16'h0900, 0, 0, 1, 1, 4'h3, 0, 0, 3);
    add(4'b0100, 16'h0900, 0, 0, 1, 1, 4'h3, 1, 1, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h3, 0, 1, 4);
    add(4'b0000, 16'h0000, 2, 0, 1, 0, 4'h3, 0, 0, 1);
    // Ack coincident with acceptance of 2 while a key and overrun are pending.
    add(4'b1000, 16'h6000, 0, 0, 0, 0, 4'h3, 0, 0, 3);
    add(4'b1000, 16'h6000, 0, 0, 0, 1, 4'h6, 1, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h6, 0, 0, 4);
    add(4'b0001, 16'h0008, 0, 0, 1, 1, 4'h6, 0, 0, 3);
    add(4'b0001, 16'h0008, 0, 0, 1, 1, 4'h6, 1, 1, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h6, 0, 1, 4);
    add(4'b0100, 16'h0200, 0, 0, 1, 1, 4'h6, 0, 1, 3);
    add(4'b0100, 16'h0200, 1, 0, 1, 1, 4'h2, 1, 0, 1);
    add(4'b0000, 16'h0000, 0, 0, 1, 1, 4'h2, 0, 0, 4);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", KEY_VALID, 1'b0);
    chk("rst_code", KEY_CODE, 4'h0);
    chk("rst_int", KEY_INT, 1'b0);
    chk("rst_overrun", OVERRUN, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    for (int k = 0; k < tbl.size(); k++) run_frame(tbl[k], k);

    // Two KEY(1) frames put the FSM in PRESS_DEB with cnt=2, then reset mid-frame.
    h.pm = 4'b1000; h.codes = 16'h1000; h.ack = 0; h.junk = 0;
    h.mid = 1; h.v = 1; h.c = 4'h2; h.i = 0; h.o = 0;
    run_frame(h, 100);
    run_frame(h, 101);
    SCAN_COL = 4'b1000; SCAN_PRESS = 1'b1; SCAN_DATA = 4'h1;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_valid", KEY_VALID, 1'b0);
    chk("async_rst_code", KEY_CODE, 4'h0);
    chk("async_rst_int", KEY_INT, 1'b0);
    chk("async_rst_overrun", OVERRUN, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    // Orphan F and D columns with no B since reset must not count as a frame.
    SCAN_COL = 4'b0010; SCAN_PRESS = 1'b1; SCAN_DATA = 4'h1;
    tick;
    SCAN_COL = 4'b0001;
    tick;
    SCAN_COL = 4'b0000; SCAN_PRESS = 1'b0;
    chk("orphan_valid", KEY_VALID, 1'b0);
    h.mid = 0; h.v = 0; h.c = 4'h0; h.i = 0; h.o = 0;
    for (int k = 0; k < 3; k++) run_frame(h, 102 + k);
    h.v = 1; h.c = 4'h1; h.i = 1;
    run_frame(h, 105);

    tick;
    tick;
    chk("int_pulse_total", int_pulses, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_capture.md
Name: key_event_capture

Overview:
- Consumer end of the keypad scan interface.
- Monitors the scanner's per-column output stream: one-hot column drive plus DATA/PRESS, one column per CLK cycle, 4-cycle frame.
- Debounces the scanned key across whole frames and latches one key code per physical press.
- Presents the latched code to the MCU with a valid/interrupt/acknowledge handshake; no auto-repeat.

Parameters:
- DEB_FRAMES, 4, consecutive identical frames required to accept a press, and also to accept a release (legal range 1..15).
- CODE_W, 4, width of the key code.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- SCAN_COL  in  4  one-hot column drive from the scanner, bit3..0 = B,G,F,D; B starts a frame, D ends it.
- SCAN_DATA  in  CODE_W  key code for the current column; ignored when SCAN_PRESS=0.
- SCAN_PRESS  in  1  a row is active in the current column.
- KEY_ACK  in  1  MCU acknowledge pulse; consumes the pending key.
- KEY_CODE  out  CODE_W  last accepted key code.
- KEY_VALID  out  1  a key is pending and not yet acknowledged.
- KEY_INT  out  1  one-cycle interrupt pulse when a new key is accepted.
- OVERRUN  out  1  sticky: a key was accepted while KEY_VALID was already 1.

Behaviour:
- Reset (async, RST_N=0): all outputs 0, FSM in IDLE, debounce counter 0, frame accumulators cleared.

Frame accumulation:
- A cycle with SCAN_COL not one-hot is ignored entirely.
- Cycle with SCAN_COL[3] (B): load the accumulators from this cycle only:
  - f_press = SCAN_PRESS
  - f_code = SCAN_DATA if pressed, else 0
  - f_multi = 0
- Cycles with G, F or D:
  - If SCAN_PRESS=1 and f_press=1, set f_multi.
  - If SCAN_PRESS=1 and f_press=0, set f_press and load f_code.
- Frame result is evaluated on the D cycle and includes the D-cycle inputs.
- Frame classes: NONE (no press); KEY(code) (exactly one press); MULTI (two or more presses).
- A D cycle with no B cycle since reset is discarded.

FSM, transitions evaluated only at frame end:
- IDLE:
  - KEY(c): cand<=c, cnt<=1. If DEB_FRAMES=1, accept now (see acceptance); otherwise go to PRESS_DEB.
  - Other frames: stay in IDLE.
- PRESS_DEB:
  - KEY(cand): cnt++. When cnt reaches DEB_FRAMES, accept and go to HELD.
  - KEY(other code): cand<=new code, cnt<=1.
  - NONE or MULTI: go to IDLE, cnt<=0.
- HELD:
  - NONE: cnt<=1, go to REL_DEB (with DEB_FRAMES=1, go straight to IDLE).
  - Any other frame: stay in HELD; no new event even if the code changes.
- REL_DEB:
  - NONE: cnt++. At DEB_FRAMES go to IDLE.
  - Any other frame: go back to HELD, cnt<=0.

Acceptance (takes effect in the cycle after the D cycle):
- KEY_CODE<=cand, KEY_VALID<=1, KEY_INT=1 for exactly one cycle.
- Latency: a clean press reaches KEY_VALID=1 exactly 4*DEB_FRAMES cycles after the first B cycle of the first pressed frame.

Handshake:
- KEY_ACK=1 with KEY_VALID=1: KEY_VALID<=0 and OVERRUN<=0 next cycle.
- KEY_ACK with KEY_VALID=0: no effect.
- Acceptance with KEY_VALID=1 and no ACK that cycle: KEY_CODE keeps its old value, OVERRUN<=1, KEY_INT still pulses.
- Acceptance and KEY_ACK in the same cycle: acceptance wins; KEY_VALID stays 1, KEY_CODE updates, OVERRUN<=0.

Other rules:
- The debounce counter saturates and never wraps; width is $clog2(DEB_FRAMES+1).
- Reset mid-frame or mid-debounce discards all partial state; the next valid frame starts at a B cycle.

Decomposition:
- Shared package kbd_pkg holds:
  - the state typedef {IDLE, PRESS_DEB, HELD, REL_DEB};
  - column bit-index constants COL_B=3, COL_G=2, COL_F=1, COL_D=0;
  - CODE_W.
- One sub-module, scan_frame_acc: the per-frame accumulator. Outputs frame_done, f_press, f_multi, f_code.
- FSM and handshake stay in the top module.

Test Plan:
- Reset, with DEB_FRAMES=4, code 5 held in column G for 6 frames: KEY_VALID rises 16 cycles after the first B cycle; KEY_CODE=5; exactly one KEY_INT pulse; no second event while the key is held.
- Bounce: frames KEY(7), NONE, KEY(7)x4: acceptance only after the final 4 frames; KEY_CODE=7.
- Two keys in one frame (codes 1 and 4): MULTI frame, no acceptance; counter back to IDLE; then KEY(4)x4 is accepted with KEY_CODE=4.
- No ACK between two clean presses (3, then 9): KEY_CODE stays 3, OVERRUN=1, two KEY_INT pulses. Then KEY_ACK: KEY_VALID=0 and OVERRUN=0 next cycle.
- KEY_ACK in the same cycle as acceptance of code 2: KEY_VALID stays 1, KEY_CODE=2, OVERRUN=0.
- RST_N asserted asynchronously mid PRESS_DEB (cnt=2): outputs 0 immediately; a subsequent press needs a full 4 frames to be accepted.
